// File: rtl/param_loader_pkg.sv
// param_loader_pkg: shared types and sizing helpers for param_stream_loader.
//   state_e            loader FSM states (CHECK only reachable with checksum)
//   err_e              err_code encodings
//   CKSUM_BYTES        1 when PARAM_LOADER_CKSUM_EN is defined, else 0
//   frame_data_bytes() data bytes per frame from word width and count
package param_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_TIMEOUT  = 2'b01,
      ERR_CKSUM    = 2'b10,
      ERR_OVERFLOW = 2'b11
   } err_e;

`ifdef PARAM_LOADER_CKSUM_EN
   localparam int unsigned CKSUM_BYTES = 1;
`else
   localparam int unsigned CKSUM_BYTES = 0;
`endif

   function automatic int unsigned frame_data_bytes(input int unsigned word_w,
                                                    input int unsigned num_words);
      return (word_w / 8) * num_words;
   endfunction

endpackage

// File: rtl/pl_strobe_sync.sv
// pl_strobe_sync: 2-flop synchronizer plus registered rising-edge detector.
//   clk, rst      clock, synchronous active-high reset
//   i_strobe      asynchronous byte strobe
//   o_byte_stb    one-cycle pulse, two cycles after i_strobe is first sampled high
// Runs independently of the loader enable so edge history never goes stale.
module pl_strobe_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_strobe,
   output logic o_byte_stb
);

   logic r_sync1;
   logic r_sync2;
   logic r_hist;
   logic r_stb;

   // Synchronize, keep one cycle of history, register the rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_hist  <= 1'b0;
         r_stb   <= 1'b0;
      end else begin
         r_sync1 <= i_strobe;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
         r_stb   <= r_sync2 & ~r_hist;
      end
   end

   assign o_byte_stb = r_stb;

endmodule

// File: rtl/param_stream_loader.sv
// param_stream_loader: assembles NUM_WORDS x WORD_W words from a strobed byte
// stream into a shadow buffer and commits them atomically with a start pulse.
//   clk, rst     clock, synchronous active-high reset
//   ena          enable; low freezes FSM, counters, shadow and outputs
//   in_data      byte pins (little-endian within a word, word 0 first)
//   in_strobe    asynchronous byte strobe, one rising edge per byte
//   core_busy    compute core busy; commit waits for it to drop
//   words_o      committed words, word 0 in the LSBs
//   start_calc   one-cycle pulse on commit
//   load_busy    high while a frame is in progress (state not IDLE)
//   err_code     00 none, 01 timeout, 10 checksum, 11 overflow (sticky)
// Build option: PARAM_LOADER_CKSUM_EN adds a trailing XOR checksum byte.
module param_stream_loader
   import param_loader_pkg::*;
#(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned NUM_WORDS = 2,
   parameter int unsigned TIMEOUT_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ena,
   input  logic [7:0]                  in_data,
   input  logic                        in_strobe,
   input  logic                        core_busy,
   output logic [NUM_WORDS*WORD_W-1:0] words_o,
   output logic                        start_calc,
   output logic                        load_busy,
   output logic [1:0]                  err_code
);

   localparam int unsigned DATA_BYTES  = frame_data_bytes(WORD_W, NUM_WORDS);
   localparam int unsigned TOTAL_BYTES = DATA_BYTES + CKSUM_BYTES;
   localparam int unsigned IDX_W       = $clog2(TOTAL_BYTES + 1);
   localparam int unsigned DATA_W      = DATA_BYTES * 8;

   localparam logic [IDX_W-1:0]     LAST_DATA_IDX = IDX_W'(DATA_BYTES - 1);
   localparam logic [TIMEOUT_W-1:0] TO_ONES       = '1;
   // Count value seen on the last idle cycle before saturation.
   localparam logic [TIMEOUT_W-1:0] TO_LAST       = TO_ONES - TIMEOUT_W'(1);

`ifdef PARAM_LOADER_CKSUM_EN
   localparam state_e AFTER_DATA = CHECK;
`else
   localparam state_e AFTER_DATA = DONE;
`endif

   logic                 w_byte_stb;
   state_e               r_state;
   logic [IDX_W-1:0]     r_idx;
   logic [TIMEOUT_W-1:0] r_to_cnt;
   logic [DATA_W-1:0]    r_shadow;
   logic [DATA_W-1:0]    r_words;
   logic                 r_start_calc;
   logic                 r_load_busy;
   err_e                 r_err;
`ifdef PARAM_LOADER_CKSUM_EN
   logic [7:0]           r_xor;
`endif

   pl_strobe_sync u_strobe_sync (
      .clk        (clk),
      .rst        (rst),
      .i_strobe   (in_strobe),
      .o_byte_stb (w_byte_stb)
   );

   // Loader FSM with registered outputs; ena gates every state update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_to_cnt     <= '0;
         r_shadow     <= '0;
         r_words      <= '0;
         r_start_calc <= 1'b0;
         r_load_busy  <= 1'b0;
         r_err        <= ERR_NONE;
`ifdef PARAM_LOADER_CKSUM_EN
         r_xor        <= '0;
`endif
      end else begin
         r_start_calc <= 1'b0;
         if (ena) begin
            case (r_state)
               IDLE: begin
                  if (w_byte_stb) begin
                     r_shadow[7:0] <= in_data;
`ifdef PARAM_LOADER_CKSUM_EN
                     r_xor         <= in_data;
`endif
                     r_idx         <= IDX_W'(1);
                     r_to_cnt      <= '0;
                     r_err         <= ERR_NONE;
                     r_load_busy   <= 1'b1;
                     r_state       <= (DATA_BYTES == 1) ? AFTER_DATA : LOAD;
                  end
               end

               // LOAD and CHECK share the inter-byte timeout; a byte wins over saturation.
               LOAD, CHECK: begin
                  if (w_byte_stb) begin
                     r_to_cnt <= '0;
`ifdef PARAM_LOADER_CKSUM_EN
                     if (r_state == CHECK) begin
                        r_idx <= '0;
                        if (in_data == r_xor) begin
                           r_state <= DONE;
                        end else begin
                           r_err       <= ERR_CKSUM;
                           r_shadow    <= '0;
                           r_load_busy <= 1'b0;
                           r_state     <= IDLE;
                        end
                     end else
`endif
                     begin
                        for (int b = 0; b < int'(DATA_BYTES); b++) begin
                           if (r_idx == IDX_W'(b)) r_shadow[b*8 +: 8] <= in_data;
                        end
`ifdef PARAM_LOADER_CKSUM_EN
                        r_xor <= r_xor ^ in_data;
`endif
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_idx == LAST_DATA_IDX) r_state <= AFTER_DATA;
                     end
                  end else if (r_to_cnt == TO_LAST) begin
                     r_err       <= ERR_TIMEOUT;
                     r_shadow    <= '0;
                     r_idx       <= '0;
                     r_to_cnt    <= '0;
                     r_load_busy <= 1'b0;
                     r_state     <= IDLE;
                  end else begin
                     r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
                  end
               end

               // Bytes arriving while the frame waits are dropped but flagged.
               DONE: begin
                  if (w_byte_stb) r_err <= ERR_OVERFLOW;
                  if (!core_busy) begin
                     r_words      <= r_shadow;
                     r_start_calc <= 1'b1;
                     r_idx        <= '0;
                     r_load_busy  <= 1'b0;
                     r_state      <= IDLE;
                  end
               end

               default: begin
                  r_load_busy <= 1'b0;
                  r_state     <= IDLE;
               end
            endcase
         end
      end
   end

   assign words_o    = r_words;
   assign start_calc = r_start_calc;
   assign load_busy  = r_load_busy;
   assign err_code   = r_err;

endmodule

// File: tb/tb_param_stream_loader.sv
// tb_param_stream_loader: directed, table-driven bench for param_stream_loader
// (WORD_W=32, NUM_WORDS=2, TIMEOUT_W=4). Adapts to PARAM_LOADER_CKSUM_EN.
module tb_param_stream_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic [7:0]  in_data;
   logic        in_strobe;
   logic        core_busy;
   logic [63:0] words_o;
   logic        start_calc;
   logic        load_busy;
   logic [1:0]  err_code;

   always #5 clk = ~clk;

   param_stream_loader #(
      .WORD_W    (32),
      .NUM_WORDS (2),
      .TIMEOUT_W (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .in_data    (in_data),
      .in_strobe  (in_strobe),
      .core_busy  (core_busy),
      .words_o    (words_o),
      .start_calc (start_calc),
      .load_busy  (load_busy),
      .err_code   (err_code)
   );

   int          cyc = 0;
   int          n_start = 0;
   int          last_start_cyc = -1;
   int          last_k = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [63:0] exp_words;

   always @(posedge clk) cyc <= cyc + 1;

   // Count start pulses and note the cycle in which each one is seen.
   always @(negedge clk) begin
      if (start_calc) begin
         n_start        = n_start + 1;
         last_start_cyc = cyc;
      end
   end

   typedef struct {
      logic [63:0] tx;        // data bytes in send order, first byte in MSBs
      logic [7:0]  cksum;
      int          busy_cyc;  // cycles core_busy stays high after the frame
      bit          extra;     // one extra byte while waiting for the core
      bit          commit;
      logic [63:0] exp_words;
      logic [1:0]  exp_err;
   } vec_t;

   vec_t vecs [4];

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Strobe high 4 cycles (covers capture at k+3), low 2 cycles.
   task automatic send_byte(input logic [7:0] b);
      in_data   = b;
      in_strobe = 1'b1;
      tick(1);
      last_k = cyc;
      tick(3);
      in_strobe = 1'b0;
      tick(2);
   endtask

   task automatic send_frame(input logic [63:0] tx);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] bt;
         bt = tx[63-8*i -: 8];
         send_byte(bt);
      end
   endtask

   initial begin
      // Checksums are the XOR of the eight data bytes.
      vecs[0] = '{64'h44332211_0100A5A5, 8'h45, 0,  1'b0, 1'b1, 64'hA5A50001_11223344, 2'b00};
      vecs[1] = '{64'h01020304_05060708, 8'h08, 20, 1'b1, 1'b1, 64'h08070605_04030201, 2'b11};
`ifdef PARAM_LOADER_CKSUM_EN
      vecs[2] = '{64'h10203040_50607080, 8'h00, 0,  1'b0, 1'b0, 64'h0,                 2'b10};
`else
      vecs[2] = '{64'h10203040_50607080, 8'h00, 0,  1'b0, 1'b1, 64'h80706050_40302010, 2'b00};
`endif
      vecs[3] = '{64'hFFEEDDCC_BBAA9988, 8'h00, 5,  1'b0, 1'b1, 64'h8899AABB_CCDDEEFF, 2'b00};

      rst = 1'b1; ena = 1'b1; in_data = 8'h00; in_strobe = 1'b0; core_busy = 1'b0;
      tick(3);
      check("rst_words", words_o, 64'h0);
      check("rst_start", 64'(start_calc), 64'h0);
      check("rst_busy",  64'(load_busy), 64'h0);
      check("rst_err",   64'(err_code), 64'h0);
      rst = 1'b0;
      tick(2);

      // Timeout: three bytes then silence; fires on the 15th idle cycle.
      begin
         int k;
         send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
         k = last_k;
         tick((k + 17) - cyc);
         check("to_pre_busy", 64'(load_busy), 64'h1);
         check("to_pre_err",  64'(err_code), 64'h0);
         tick(1);
         check("to_err",   64'(err_code), 64'h1);
         check("to_busy",  64'(load_busy), 64'h0);
         check("to_words", words_o, 64'h0);
         check("to_nostart", 64'(n_start), 64'h0);
      end

      // Reset mid-frame, then a full frame commits once.
      begin
         int s0;
         send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h01);
         rst = 1'b1;
         tick(1);
         rst = 1'b0;
         check("mrst_busy",  64'(load_busy), 64'h0);
         check("mrst_err",   64'(err_code), 64'h0);
         check("mrst_words", words_o, 64'h0);
         s0 = n_start;
         send_frame(64'h44332211_0100A5A5);
`ifdef PARAM_LOADER_CKSUM_EN
         send_byte(8'h45);
`endif
         tick(3);
         check("mrst_nstart", 64'(n_start - s0), 64'h1);
         check("mrst_lat",    64'(last_start_cyc), 64'(last_k + 4));
         check("mrst_words2", words_o, 64'hA5A50001_11223344);
         exp_words = 64'hA5A50001_11223344;
      end

      // Table-driven frames.
      for (int r = 0; r < 4; r++) begin
         int s0;
         int rel;
         s0 = n_start;
         core_busy = (vecs[r].busy_cyc != 0);
         send_frame(vecs[r].tx);
`ifdef PARAM_LOADER_CKSUM_EN
         send_byte(vecs[r].cksum);
`endif
         if (vecs[r].busy_cyc != 0) begin
            check($sformatf("v%0d_hold_words", r), words_o, exp_words);
            check($sformatf("v%0d_hold_nostart", r), 64'(n_start - s0), 64'h0);
            check($sformatf("v%0d_hold_busy", r), 64'(load_busy), 64'h1);
            if (vecs[r].extra) send_byte(8'hC3);
            tick(vecs[r].busy_cyc - (vecs[r].extra ? 6 : 0));
            check($sformatf("v%0d_hold_words2", r), words_o, exp_words);
            core_busy = 1'b0;
            rel = cyc + 1;
            tick(3);
            if (vecs[r].commit)
               check($sformatf("v%0d_lat", r), 64'(last_start_cyc), 64'(rel));
         end else begin
            tick(3);
            if (vecs[r].commit)
               check($sformatf("v%0d_lat", r), 64'(last_start_cyc), 64'(last_k + 4));
         end
         check($sformatf("v%0d_nstart", r), 64'(n_start - s0), 64'(vecs[r].commit));
         if (vecs[r].commit) exp_words = vecs[r].exp_words;
         check($sformatf("v%0d_words", r), words_o, exp_words);
         check($sformatf("v%0d_err", r), 64'(err_code), 64'(vecs[r].exp_err));
         check($sformatf("v%0d_busy", r), 64'(load_busy), 64'h0);
      end

      // ena low mid-frame with strobes toggling: bytes lost, timeout frozen.
      begin
         int s0;
         s0 = n_start;
         send_byte(8'h5A); send_byte(8'h11); send_byte(8'h22);
         ena = 1'b0; in_data = 8'hEE; in_strobe = 1'b1;
         tick(3);
         in_strobe = 1'b0;
         tick(2);
         in_strobe = 1'b1;
         tick(3);
         in_strobe = 1'b0;
         tick(2);
         check("ena_busy", 64'(load_busy), 64'h1);
         check("ena_err",  64'(err_code), 64'h0);
         ena = 1'b1;
         send_byte(8'h33); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
`ifdef PARAM_LOADER_CKSUM_EN
         send_byte(8'h5A);
`endif
         tick(3);
         check("ena_nstart", 64'(n_start - s0), 64'h1);
         check("ena_words",  words_o, 64'h77665544_3322115A);
         check("ena_err2",   64'(err_code), 64'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
